// File: rtl/booth_r4_mul.sv
// booth_r4_mul: radix-4 (modified Booth) sequential multiplier with signed/unsigned mode and start/busy/done handshake
module booth_r4_mul #(
   parameter int N  = 16,
   parameter int CW = $clog2(N/2+2)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   a_in,
   input  logic [N-1:0]   b_in,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);
   if (N < 4 || N % 2 != 0) begin : g_bad_n
      $error("booth_r4_mul: N must be even and >= 4");
   end
   typedef enum logic {IDLE, RUN} state_t;
   state_t         state;
   logic [N+3:0]   acc;
   logic [N+1:0]   mcand;
   logic [N+1:0]   mplier;
   logic           q_m1;
   logic [CW-1:0]  cnt;
   logic [N+3:0]   m1;
   logic [N+3:0]   m2;
   logic [N+3:0]   addend;
   logic [N+3:0]   acc_sum;
   logic [2*N+6:0] step;
   // Recode {Q[1:0],q[-1]} into a Booth digit, accumulate digit*M, then shift {A,Q,q[-1]} right by two
   always_comb begin
      m1 = {{2{mcand[N+1]}}, mcand};
      m2 = {mcand[N+1], mcand, 1'b0};
      case ({mplier[1:0], q_m1})
         3'b001, 3'b010: addend = m1;
         3'b011:         addend = m2;
         3'b100:         addend = -m2;
         3'b101, 3'b110: addend = -m1;
         default:        addend = '0;
      endcase
      acc_sum = acc + addend;
      step    = $signed({acc_sum, mplier, q_m1}) >>> 2;
   end
   // Control FSM: capture operands on start, run N/2+1 digit steps, publish product with a one-cycle done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mcand  <= {{2{signed_mode & a_in[N-1]}}, a_in};
               mplier <= {{2{signed_mode & b_in[N-1]}}, b_in};
               q_m1   <= 1'b0;
               acc    <= '0;
               cnt    <= CW'(N/2+1);
               state  <= RUN;
               busy   <= 1'b1;
            end
            RUN: begin
               {acc, mplier, q_m1} <= step;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  product <= step[2*N:1];
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_r4_mul.sv
// tb_booth_r4_mul: scoreboard bench for booth_r4_mul at N=16 and N=8
module tb_booth_r4_mul;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0;
   int passes = 0;

   logic        s16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [31:0] p16;
   logic        s8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] p8;

   booth_r4_mul #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .start(s16), .signed_mode(sm16),
      .a_in(a16), .b_in(b16), .busy(busy16), .done(done16), .product(p16));
   booth_r4_mul #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(s8), .signed_mode(sm8),
      .a_in(a8), .b_in(b8), .busy(busy8), .done(done8), .product(p8));

   typedef struct { logic [31:0] exp; int t; } exp_t;
   exp_t q16[$];
   exp_t q8[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] ref16(input logic sm, input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] sa, sb;
      logic [31:0] ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {16'b0, a};
      ub = {16'b0, b};
      return sm ? sa * sb : ua * ub;
   endfunction

   function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa, sb;
      logic [15:0] ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {8'b0, a};
      ub = {8'b0, b};
      return sm ? sa * sb : ua * ub;
   endfunction

   // monitor for the N=16 instance
   always @(negedge clk) if (done16) begin
      exp_t e;
      if (q16.size() == 0) begin
         checks++;
         $display("FAIL spurious_done16: done with product %h, no request outstanding", p16);
      end else begin
         e = q16.pop_front();
         check("product16", p16, e.exp);
         check("latency16", 32'(cyc - e.t), 32'd9);
         check("busy16_in_done", {31'b0, busy16}, 32'd0);
      end
   end

   // monitor for the N=8 instance
   always @(negedge clk) if (done8) begin
      exp_t e;
      if (q8.size() == 0) begin
         checks++;
         $display("FAIL spurious_done8: done with product %h, no request outstanding", p8);
      end else begin
         e = q8.pop_front();
         check("product8", {16'b0, p8}, e.exp);
         check("latency8", 32'(cyc - e.t), 32'd5);
         check("busy8_in_done", {31'b0, busy8}, 32'd0);
      end
   end

   task automatic issue16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input bit acc);
      exp_t e;
      sm16 = sm; a16 = a; b16 = b; s16 = 1'b1;
      e.exp = exp;
      e.t = cyc + 1;
      if (acc) q16.push_back(e);
      @(negedge clk);
      s16 = 1'b0; sm16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
   endtask

   task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
      exp_t e;
      sm8 = sm; a8 = a; b8 = b; s8 = 1'b1;
      e.exp = {16'b0, exp};
      e.t = cyc + 1;
      q8.push_back(e);
      @(negedge clk);
      s8 = 1'b0; sm8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
   endtask

   task automatic drain;
      for (int i = 0; i < 40 && (q16.size() != 0 || q8.size() != 0); i++) begin
         @(negedge clk);
         #1;
      end
      if (q16.size() != 0 || q8.size() != 0) begin
         checks++;
         $display("FAIL drain_timeout: pending %0d/%0d expected 0", q16.size(), q8.size());
         q16.delete();
         q8.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic sm;
      logic [15:0] a, b;
      logic [7:0] c, d;
      repeat (2) @(negedge clk);
      check("reset_busy16", {31'b0, busy16}, 32'd0);
      check("reset_done16", {31'b0, done16}, 32'd0);
      check("reset_product16", p16, 32'd0);
      check("reset_product8", {16'b0, p8}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue16(1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 1'b1);
      check("busy16_after_start", {31'b0, busy16}, 32'd1);
      drain();
      issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1); drain();
      issue16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b1); drain();
      issue16(1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1); drain();
      issue16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 1'b1); drain();
      issue16(1'b1, 16'h8000, 16'h0002, 32'hFFFF0000, 1'b1); drain();
      issue16(1'b0, 16'h8000, 16'h0002, 32'h00010000, 1'b1); drain();
      issue16(1'b1, 16'h0000, 16'h1234, 32'h00000000, 1'b1); drain();
      issue16(1'b0, 16'hABCD, 16'h0000, 32'h00000000, 1'b1); drain();
      issue8(1'b1, 8'h80, 8'h80, 16'h4000); drain();
      issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01); drain();
      issue8(1'b1, 8'h80, 8'h7F, 16'hC080); drain();

      issue16(1'b0, 16'd7, 16'd6, 32'd42, 1'b1);
      repeat (2) @(negedge clk);
      issue16(1'b0, 16'd2, 16'd3, 32'd0, 1'b0);
      for (int i = 0; i < 20 && !done16; i++) @(negedge clk);
      issue16(1'b0, 16'd10, 16'd10, 32'd100, 1'b1);
      check("product16_held", p16, 32'd42);
      drain();

      issue16(1'b1, 16'h1234, 16'h5678, 32'd0, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy16", {31'b0, busy16}, 32'd0);
      check("abort_done16", {31'b0, done16}, 32'd0);
      check("abort_product16", p16, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      issue16(1'b0, 16'd123, 16'd456, 32'h0000DB18, 1'b1); drain();

      for (int i = 0; i < 1000; i++) begin
         sm = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
         issue16(sm, a, b, ref16(sm, a, b), 1'b1);
         drain();
      end
      for (int i = 0; i < 1000; i++) begin
         sm = 1'($urandom); c = 8'($urandom); d = 8'($urandom);
         issue8(sm, c, d, ref8(sm, c, d));
         drain();
      end
      repeat (12) @(negedge clk);
      check("queues_empty", 32'(q16.size() + q8.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
